// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: code table, blank code and digit positions.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-high segment codes in gfedcba order; entry i encodes hex value i.
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_TENTHS  = 2'd0;
    localparam logic [1:0] DIG_UNITS   = 2'd1;
    localparam logic [1:0] DIG_TENS    = 2'd2;
    localparam logic [1:0] DIG_MINUTES = 2'd3;

    // Encoder side of the table, used by the display driver.
    function automatic logic [6:0] seg_encode(input logic [3:0] val);
        return SEG_CODES[val];
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment decoder: active-high gfedcba pattern to hex value.
module seg_decode
    import seg_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] val_o,
    output logic       is_blank_o,
    output logic       is_bad_o
);

    // Table lookup; anything that is neither a known code nor blank is bad.
    always_comb begin
        val_o      = 4'd0;
        is_blank_o = (pat_i == SEG_BLANK);
        is_bad_o   = (pat_i != SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pat_i == SEG_CODES[i]) begin
                val_o    = 4'(i);
                is_bad_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_capture.sv
// Captures a multiplexed active-low seven-segment display into a 4-digit frame.
module seg_capture
    import seg_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  disp,
    input  logic [3:0]  mux,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        valid,
    output logic        frame_stb,
    output logic        pat_err
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [6:0]       disp_q, disp_prev_q;
    logic [3:0]       mux_q, mux_prev_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic [3:0]       seen_q, seen_d;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic [3:0]       sblank_q, sblank_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       blank_q, blank_d;
    logic             valid_q, valid_d;
    logic             frame_stb_q, pat_err_q;

    logic [3:0] sel;
    logic       one_hot, same, settled, cap_ok, cap_bad, frame, timed_out;
    logic [1:0] idx;
    logic [3:0] dec_val;
    logic       dec_blank, dec_bad;

    seg_decode u_dec (
        .pat_i      (~disp_q),
        .val_o      (dec_val),
        .is_blank_o (dec_blank),
        .is_bad_o   (dec_bad)
    );

    // Settle/capture decision, seen tracking, frame assembly and idle timeout.
    always_comb begin
        sel     = ~mux_q;
        one_hot = $onehot(sel);
        same    = ({mux_q, disp_q} == {mux_prev_q, disp_prev_q});

        cnt_d = '0;
        if (one_hot) begin
            if (!same)                        cnt_d = CW'(1);
            else if (cnt_q != CW'(SETTLE))    cnt_d = cnt_q + CW'(1);
            else                              cnt_d = cnt_q;
        end
        // Fire once when the count first reaches SETTLE; a saturated dwell is quiet.
        settled = one_hot && (cnt_d == CW'(SETTLE)) && !(same && (cnt_q == CW'(SETTLE)));
        cap_ok  = settled && !dec_bad;
        cap_bad = settled && dec_bad;

        idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel[k]) idx = 2'(k);
        end

        frame = (seen_q == 4'hF);

        if (cap_ok)                        idle_d = '0;
        else if (idle_q == IW'(TIMEOUT))   idle_d = idle_q;
        else                               idle_d = idle_q + IW'(1);
        timed_out = (idle_d == IW'(TIMEOUT));

        // A capture on the frame-update cycle lands in the freshly cleared set.
        seen_d = (frame || timed_out) ? 4'h0 : seen_q;
        if (cap_ok) seen_d = seen_d | sel;

        shadow_d = shadow_q;
        sblank_d = sblank_q;
        if (cap_ok) begin
            shadow_d[idx] = dec_val;
            sblank_d[idx] = dec_blank;
        end

        digits_d = frame ? shadow_q : digits_q;
        blank_d  = frame ? sblank_q : blank_q;

        if (frame)          valid_d = 1'b1;
        else if (timed_out) valid_d = 1'b0;
        else                valid_d = valid_q;
    end

    // State registers; reset wins over any event in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q      <= '1;
            mux_q       <= '1;
            disp_prev_q <= '1;
            mux_prev_q  <= '1;
            cnt_q       <= '0;
            idle_q      <= '0;
            seen_q      <= '0;
            shadow_q    <= '0;
            sblank_q    <= '1;
            digits_q    <= '0;
            blank_q     <= 4'hF;
            valid_q     <= 1'b0;
            frame_stb_q <= 1'b0;
            pat_err_q   <= 1'b0;
        end else begin
            disp_q      <= disp;
            mux_q       <= mux;
            disp_prev_q <= disp_q;
            mux_prev_q  <= mux_q;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            seen_q      <= seen_d;
            shadow_q    <= shadow_d;
            sblank_q    <= sblank_d;
            digits_q    <= digits_d;
            blank_q     <= blank_d;
            valid_q     <= valid_d;
            frame_stb_q <= frame;
            pat_err_q   <= cap_bad;
        end
    end

    assign digits    = digits_q;
    assign blank     = blank_q;
    assign valid     = valid_q;
    assign frame_stb = frame_stb_q;
    assign pat_err   = pat_err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture (SETTLE=4, TIMEOUT=40).
module tb_seg_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  disp = 7'h7F;
    logic [3:0]  mux = 4'hF;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        valid, frame_stb, pat_err;

    int vecs = 0;
    int errs = 0;
    int stb_cnt = 0;
    int perr_cnt = 0;
    int stb0, perr0;

    seg_capture #(.SETTLE(4), .TIMEOUT(40)) dut (
        .clk       (clk),
        .reset     (reset),
        .disp      (disp),
        .mux       (mux),
        .digits    (digits),
        .blank     (blank),
        .valid     (valid),
        .frame_stb (frame_stb),
        .pat_err   (pat_err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_stb) stb_cnt  <= stb_cnt + 1;
        if (pat_err)   perr_cnt <= perr_cnt + 1;
    end

    // Independent segment table (active-high gfedcba).
    function automatic logic [6:0] code(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Drive raw bus values for n rising edges; returns 1ns after the last edge.
    task automatic hold_raw(input logic [3:0] m, input logic [6:0] d, input int n);
        mux  = m;
        disp = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Show hex value v on digit k for n edges.
    task automatic hold(input int k, input int v, input int n);
        logic [3:0] one;
        one = 4'b0001 << k;
        hold_raw(~one, ~code(v), n);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] one2;
        one2 = 4'b0100;

        // Reset state
        hold_raw(4'hF, 7'h7F, 3);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_blank", 32'(blank), 32'hF);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_stb", 32'(frame_stb), 32'h0);
        check("rst_perr", 32'(pat_err), 32'h0);
        reset = 1'b0;

        // Basic scan 1,2,3,4 with exact capture-to-strobe latency
        stb0 = stb_cnt; perr0 = perr_cnt;
        hold(0, 1, 8);
        hold(1, 2, 8);
        hold(2, 3, 8);
        hold(3, 4, 4);          // fourth sample in; capture commits on next edge
        hold(3, 4, 1);          // completing capture edge
        check("lat_stb_early", 32'(frame_stb), 32'h0);
        check("lat_dig_early", 32'(digits), 32'h0);
        hold(3, 4, 1);          // frame edge
        check("lat_stb", 32'(frame_stb), 32'h1);
        check("lat_digits", 32'(digits), 32'h4321);
        check("lat_valid", 32'(valid), 32'h1);
        hold(3, 4, 1);
        check("stb_pulse", 32'(frame_stb), 32'h0);
        hold(3, 4, 1);
        check("scan_stb_cnt", 32'(stb_cnt - stb0), 32'd1);
        check("scan_perr_cnt", 32'(perr_cnt - perr0), 32'd0);
        check("scan_blank", 32'(blank), 32'h0);

        // Short dwell on digit 1 is not captured
        stb0 = stb_cnt;
        hold(0, 5, 8);
        hold(1, 6, 3);
        hold(2, 7, 8);
        hold(3, 8, 8);
        check("short_no_stb", 32'(stb_cnt - stb0), 32'd0);
        check("short_digits", 32'(digits), 32'h4321);
        hold(1, 6, 8);
        check("short_then_stb", 32'(stb_cnt - stb0), 32'd1);
        check("short_digits2", 32'(digits), 32'h8765);

        // Undecodable pattern on digit 2
        stb0 = stb_cnt; perr0 = perr_cnt;
        hold(0, 9, 8);
        hold(1, 0, 8);
        hold_raw(~one2, ~7'h01, 8);
        hold(3, 10, 8);         // last capture of this phase is 3 edges back
        check("bad_perr_cnt", 32'(perr_cnt - perr0), 32'd1);
        check("bad_no_stb", 32'(stb_cnt - stb0), 32'd0);
        check("bad_digits", 32'(digits), 32'h8765);

        // Idle timeout: valid falls 40 edges after the last capture
        hold_raw(4'hF, 7'h7F, 36);
        check("to_valid_before", 32'(valid), 32'h1);
        hold_raw(4'hF, 7'h7F, 1);
        check("to_valid_after", 32'(valid), 32'h0);
        check("to_digits_hold", 32'(digits), 32'h8765);

        // Multi-hot select, then a clean scan with a blank minutes digit
        stb0 = stb_cnt; perr0 = perr_cnt;
        hold_raw(4'h0, ~code(3), 20);
        check("mh_no_stb", 32'(stb_cnt - stb0), 32'd0);
        check("mh_no_perr", 32'(perr_cnt - perr0), 32'd0);
        hold(0, 11, 8);
        hold(1, 12, 8);
        hold(2, 13, 8);
        hold_raw(4'b0111, 7'h7F, 8);
        check("mh_scan_stb", 32'(stb_cnt - stb0), 32'd1);
        check("mh_scan_digits", 32'(digits), 32'h0DCB);
        check("mh_scan_blank", 32'(blank), 32'h8);
        check("mh_scan_valid", 32'(valid), 32'h1);
        check("mh_scan_perr", 32'(perr_cnt - perr0), 32'd0);

        // Reset on the completing-capture edge
        stb0 = stb_cnt;
        hold(0, 2, 8);
        hold(1, 4, 8);
        hold(2, 6, 8);
        hold(3, 8, 4);
        reset = 1'b1;
        hold(3, 8, 1);
        check("rc_stb", 32'(frame_stb), 32'h0);
        check("rc_digits", 32'(digits), 32'h0);
        check("rc_blank", 32'(blank), 32'hF);
        check("rc_valid", 32'(valid), 32'h0);
        check("rc_perr", 32'(pat_err), 32'h0);
        reset = 1'b0;
        hold(3, 8, 8);
        check("rc_no_stb", 32'(stb_cnt - stb0), 32'd0);
        check("rc_valid_after", 32'(valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter SETTLE, default 4: consecutive identical samples required before a digit is captured.
REQ-002 Parameter TIMEOUT, default 1_000_000: cycles without a capture before valid is dropped.
REQ-003 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port disp, input, 7: multiplexed segment bus, active-low; disp[0]=a through disp[6]=g.
REQ-006 Port mux, input, 4: digit select, active-low one-hot; mux[k]=0 selects digit k (0=tenths, 1=units, 2=tens, 3=minutes).
REQ-007 Port digits, output, 16: last complete frame {digit3, digit2, digit1, digit0}, 4 bits each.
REQ-008 Port blank, output, 4: blank[k]=1 when digit k was all-segments-off in the last frame.
REQ-009 Port valid, output, 1: level; a frame completed and no timeout has occurred since.
REQ-010 Port frame_stb, output, 1: one-cycle pulse when digits/blank update.
REQ-011 Port pat_err, output, 1: one-cycle pulse when a settled pattern fails to decode.

Function
REQ-012 Inputs SHALL be registered once before use; all latencies below count from that registered sample.
REQ-013 The sample SHALL be qualified only when ~mux has exactly one bit set; zero-hot or multi-hot resets the settle counter, captures nothing and raises no error.
REQ-014 The settle counter SHALL restart whenever the {mux, disp} sample differs from the previous cycle's sample.
REQ-015 Capture SHALL occur on the cycle the counter reaches SETTLE, exactly once per stable dwell; no recapture until the sample changes.
REQ-016 Decode of ~disp in gfedcba order, per the shared table: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
REQ-017 Pattern 00 (blank) SHALL store digit 0 with its blank bit set; no error.
REQ-018 Any other pattern SHALL pulse pat_err, leave that digit's shadow and seen bit unchanged.
REQ-019 A successful capture SHALL write the shadow register for digit k and set seen[k]; a repeat capture of the same k overwrites the shadow.
REQ-020 When seen becomes 4'b1111, the next cycle SHALL copy all shadows to digits/blank atomically, pulse frame_stb, set valid, and clear seen.
REQ-021 Capture-to-frame_stb latency SHALL be exactly 1 cycle after the completing capture.
REQ-022 The idle counter SHALL clear on every capture; at TIMEOUT it saturates, drops valid and clears seen; digits hold their values.
REQ-023 A capture coinciding with the frame update SHALL be recorded in the new, cleared seen set, not lost.

Reset
REQ-024 reset SHALL clear digits=0, blank=4'hF, valid=0, frame_stb=0, pat_err=0, seen=0, settle and idle counters=0, input registers to inactive (all ones).
REQ-025 reset SHALL take priority over every simultaneous event, including a completing frame, and abandons any partial frame.

Structure
REQ-026 Package seg_pkg SHALL hold the 16-entry segment code table, blank code, and digit-index constants, shared with the display encoder.
REQ-027 Sub-module seg_decode (combinational: 7-bit pattern -> 4-bit value, is_blank, is_bad) SHALL be instantiated once.
REQ-028 Sequential logic (input register, settle, seen, shadows, idle) SHALL remain in seg_capture; target 150-250 lines.

Verification
REQ-029 Scan 1,2,3,4 on digits 0..3 for 8 cycles each -> frame_stb once, digits=16'h4321, valid=1, pat_err never asserted.
REQ-030 Digit 1 held for 3 cycles (SETTLE=4), then switched -> no capture for digit 1, no frame_stb until a full 4-cycle dwell on digit 1.
REQ-031 Digit 2 shows disp=~7'h01 -> one pat_err pulse; frame incomplete; digits unchanged.
REQ-032 mux=4'b0000 (multi-hot) for 20 cycles -> no capture, no error; the following valid scan completes normally.
REQ-033 Valid frame, then inputs frozen at mux=4'hF for TIMEOUT cycles -> valid falls exactly at TIMEOUT; digits retain the last value.
REQ-034 reset asserted on the completing-capture cycle -> no frame_stb; all outputs at reset values on the next cycle.
